// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C command path: word layout, slave addresses,
// codec register sub-addresses and the arbiter state encoding.
package i2c_cfg_pkg;

    localparam int unsigned I2C_WORD_W = 24;

    localparam logic [7:0] AUDIO_CODEC_ADDR = 8'h34;
    localparam logic [7:0] VIDEO_DEC_ADDR   = 8'h40;

    // Codec sub-address byte is the register index shifted left by one; its LSB
    // carries data bit 8, so sources OR that bit in themselves.
    localparam logic [7:0] LIN_L       = 8'h00;
    localparam logic [7:0] LIN_R       = 8'h02;
    localparam logic [7:0] HEAD_L      = 8'h04;
    localparam logic [7:0] HEAD_R      = 8'h06;
    localparam logic [7:0] A_PATH_CTRL = 8'h08;
    localparam logic [7:0] D_PATH_CTRL = 8'h0A;
    localparam logic [7:0] POWER_ON    = 8'h0C;
    localparam logic [7:0] SET_FORMAT  = 8'h0E;
    localparam logic [7:0] SAMPLE_CTRL = 8'h10;
    localparam logic [7:0] SET_ACTIVE  = 8'h12;
    localparam logic [7:0] CODEC_RESET = 8'h1E;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitStart,
        StWaitEnd,
        StGap
    } arb_state_e;

    function automatic logic [I2C_WORD_W-1:0] mk_word(input logic [7:0] slave,
                                                      input logic [7:0] sub,
                                                      input logic [7:0] data);
        return {slave, sub, data};
    endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N_REQ.
module i2c_rr_pick #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PW-1:0]    idx_o,
    output logic             valid_o
);

    always_comb begin
        int unsigned k;
        logic [PW-1:0] kk;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        k       = 0;
        kk      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k  = (32'(ptr_i) + i) % N_REQ;
            kk = PW'(k);
            if (!valid_o && req_i[kk]) begin
                valid_o   = 1'b1;
                gnt_o[kk] = 1'b1;
                idx_o     = kk;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one I2C_Controller between several word sources,
// with NACK/timeout retry and per-requester done/error reporting.
module i2c_cmd_arbiter
    import i2c_cfg_pkg::*;
#(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                          iCLK,
    input  logic                          iRST_N,
    input  logic [N_REQ-1:0]              iREQ,
    input  logic [I2C_WORD_W*N_REQ-1:0]   iDATA,
    output logic [N_REQ-1:0]              oGNT,
    output logic [N_REQ-1:0]              oDONE,
    output logic                          oERR,
    output logic                          oBUSY,
    output logic [I2C_WORD_W-1:0]         oI2C_DATA,
    output logic                          oI2C_GO,
    input  logic                          iI2C_END,
    input  logic                          iI2C_ACK
);

    localparam int unsigned PW = $clog2(N_REQ);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GW = $clog2(GAP_CYC + 1);

    arb_state_e            state_q;
    logic [PW-1:0]         ptr_q;
    logic [PW-1:0]         idx_q;
    logic [N_REQ-1:0]      gnt_q;
    logic [N_REQ-1:0]      done_q;
    logic                  err_q;
    logic                  go_q;
    logic                  pend_q;
    logic [I2C_WORD_W-1:0] data_q;
    logic [TW-1:0]         tmo_q;
    logic [RW-1:0]         retry_q;
    logic [GW-1:0]         gap_q;

    logic [I2C_WORD_W-1:0] req_word [N_REQ];
    logic [N_REQ-1:0]      pick_gnt;
    logic [PW-1:0]         pick_idx;
    logic                  pick_valid;
    logic                  tmo_hit;
    logic                  att_ok;
    logic                  att_fail;
    logic [PW-1:0]         ptr_nxt;

    for (genvar g = 0; g < N_REQ; g++) begin : g_word
        assign req_word[g] = iDATA[g*I2C_WORD_W +: I2C_WORD_W];
    end

    i2c_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req_i   (iREQ),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign tmo_hit = (tmo_q >= TW'(TIMEOUT_CYC));
    assign ptr_nxt = (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

    // END high in WAIT_START is the idle controller, never a completion.
    always_comb begin
        att_ok   = 1'b0;
        att_fail = 1'b0;
        if (state_q == StWaitEnd && iI2C_END) begin
            att_ok   = !iI2C_ACK;
            att_fail = iI2C_ACK;
        end else if (state_q == StWaitEnd && tmo_hit) begin
            att_fail = 1'b1;
        end else if (state_q == StWaitStart && iI2C_END && tmo_hit) begin
            att_fail = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            go_q    <= 1'b0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            tmo_q   <= '0;
            retry_q <= '0;
            gap_q   <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        data_q  <= req_word[pick_idx];
                        gnt_q   <= pick_gnt;
                        idx_q   <= pick_idx;
                        retry_q <= '0;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    go_q    <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= StWaitStart;
                end
                StWaitStart, StWaitEnd: begin
                    if (!tmo_hit) begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                    if (state_q == StWaitStart && !iI2C_END) begin
                        state_q <= StWaitEnd;
                    end
                    if (att_ok || att_fail) begin
                        go_q    <= 1'b0;
                        gap_q   <= '0;
                        state_q <= StGap;
                        if (att_fail && retry_q < RW'(MAX_RETRY)) begin
                            retry_q <= retry_q + 1'b1;
                            pend_q  <= 1'b1;
                        end else begin
                            done_q <= gnt_q;
                            err_q  <= att_fail;
                            gnt_q  <= '0;
                            ptr_q  <= ptr_nxt;
                            pend_q <= 1'b0;
                        end
                    end
                end
                StGap: begin
                    if (gap_q == GW'(GAP_CYC - 1)) begin
                        state_q <= pend_q ? StIssue : StIdle;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign oGNT      = gnt_q;
    assign oDONE     = done_q;
    assign oERR      = err_q;
    assign oBUSY     = (state_q != StIdle);
    assign oI2C_DATA = data_q;
    assign oI2C_GO   = go_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Scoreboard bench for i2c_cmd_arbiter with a behavioural I2C controller model.
module tb_i2c_cmd_arbiter;

    localparam int unsigned NR   = 3;
    localparam int unsigned MR   = 3;
    localparam int unsigned GAP  = 2;
    localparam int unsigned TMO  = 64;
    localparam int MNormal   = 0;
    localparam int MNeverEnd = 1;
    localparam int MStale    = 2;

    typedef struct {
        int          idx;
        logic [23:0] data;
        logic        err;
        int          att;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [24*NR-1:0] data_in;
    logic [NR-1:0]   oGNT;
    logic [NR-1:0]   oDONE;
    logic            oERR;
    logic            oBUSY;
    logic [23:0]     oI2C_DATA;
    logic            oI2C_GO;
    logic            i2c_end;
    logic            i2c_ack;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   model_mode = MNormal;
    int   hold_cyc = 10;
    logic ack_default = 1'b0;
    logic auto_drop = 1'b1;
    logic chk_len = 1'b0;
    logic ack_q [$];
    exp_t exp_q [$];

    i2c_cmd_arbiter #(
        .N_REQ       (NR),
        .MAX_RETRY   (MR),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iREQ      (req),
        .iDATA     (data_in),
        .oGNT      (oGNT),
        .oDONE     (oDONE),
        .oERR      (oERR),
        .oBUSY     (oBUSY),
        .oI2C_DATA (oI2C_DATA),
        .oI2C_GO   (oI2C_GO),
        .iI2C_END  (i2c_end),
        .iI2C_ACK  (i2c_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [23:0] d, input logic e, input int att);
        exp_t x;
        x.idx = idx; x.data = d; x.err = e; x.att = att;
        exp_q.push_back(x);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            if (auto_drop) req = req & ~oDONE;
            n++;
        end
        if (done_cnt < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: got %0d dones, required %0d", done_cnt, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Controller model: END drops one cycle after GO rises, rises hold_cyc later.
    initial begin : ctrl_model
        int   cnt;
        logic busy;
        logic go_prev;
        cnt = 0; busy = 1'b0; go_prev = 1'b0;
        i2c_end = 1'b1;
        i2c_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !oI2C_GO) begin
                if (busy) i2c_end = 1'b1;
                busy = 1'b0;
            end else if (!go_prev) begin
                busy = 1'b1;
                cnt  = 0;
            end else if (busy) begin
                cnt++;
                if (cnt == 1 && model_mode != MStale) i2c_end = 1'b0;
                if (model_mode == MNormal && cnt == 1 + hold_cyc) begin
                    i2c_ack = (ack_q.size() > 0) ? ack_q.pop_front() : ack_default;
                    i2c_end = 1'b1;
                end
            end
            go_prev = oI2C_GO && rst_n;
        end
    end

    initial begin : monitor
        int   attempts;
        int   lo_cnt;
        int   hi_cnt;
        logic go_prev;
        logic have_fall;
        exp_t e;
        attempts = 0; lo_cnt = 0; hi_cnt = 0; go_prev = 1'b0; have_fall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                attempts = 0; lo_cnt = 0; hi_cnt = 0; go_prev = 1'b0; have_fall = 1'b0;
            end else begin
                if (oI2C_GO && !go_prev) begin
                    attempts++;
                    if (have_fall) check("go_gap", 32'(lo_cnt >= GAP + 1), 1);
                    if (exp_q.size() > 0) begin
                        check("go_gnt", 32'(oGNT), 32'(1) << exp_q[0].idx);
                        check("go_word", 32'(oI2C_DATA), 32'(exp_q[0].data));
                    end
                    hi_cnt = 0;
                end
                if (!oI2C_GO && go_prev) begin
                    have_fall = 1'b1;
                    lo_cnt = 0;
                    if (chk_len) check("go_len", hi_cnt, TMO + 1);
                end
                if (oI2C_GO) hi_cnt++;
                else lo_cnt++;
                if (|oDONE) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL done_unexpected: got oDONE=%b, required none", oDONE);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_idx", 32'(oDONE), 32'(1) << e.idx);
                        check("done_err", 32'(oERR), 32'(e.err));
                        check("done_word", 32'(oI2C_DATA), 32'(e.data));
                        check("done_attempts", attempts, e.att);
                        check("done_gnt_clr", 32'(oGNT), 0);
                    end
                    done_cnt++;
                    attempts = 0;
                end else if (oERR) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL err_without_done: got oERR=1, required 0");
                end
                go_prev = oI2C_GO;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        rst_n = 1'b0;
        req = '0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(oGNT), 0);
        check("rst_done", 32'(oDONE), 0);
        check("rst_err", 32'(oERR), 0);
        check("rst_busy", 32'(oBUSY), 0);
        check("rst_go", 32'(oI2C_GO), 0);
        check("rst_data", 32'(oI2C_DATA), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request, grant latency
        hold_cyc = 50;
        push_exp(0, 24'h340450, 1'b0, 1);
        data_in[23:0] = 24'h340450;
        req = 3'b001;
        @(negedge clk);
        check("lat_gnt", 32'(oGNT), 32'h1);
        check("lat_data", 32'(oI2C_DATA), 32'h340450);
        check("lat_go_low", 32'(oI2C_GO), 0);
        check("lat_busy", 32'(oBUSY), 1);
        @(negedge clk);
        check("lat_go_high", 32'(oI2C_GO), 1);
        wait_done(1, 200);
        check("single_empty", exp_q.size(), 0);

        // Contention from reset: order 0,1,2,0,1,2
        do_reset();
        hold_cyc = 10;
        auto_drop = 1'b0;
        data_in = {24'h400A55, 24'h340217, 24'h340017};
        for (int r = 0; r < 2; r++) begin
            push_exp(0, 24'h340017, 1'b0, 1);
            push_exp(1, 24'h340217, 1'b0, 1);
            push_exp(2, 24'h400A55, 1'b0, 1);
        end
        req = 3'b111;
        wait_done(7, 400);
        req = '0;
        auto_drop = 1'b1;
        check("cont_empty", exp_q.size(), 0);

        // NACK twice then ack; word change after grant is ignored
        ack_q.push_back(1'b1);
        ack_q.push_back(1'b1);
        ack_q.push_back(1'b0);
        data_in[47:24] = 24'h340679;
        push_exp(1, 24'h340679, 1'b0, 3);
        req = 3'b010;
        repeat (3) @(negedge clk);
        data_in[47:24] = 24'hFFFFFF;
        wait_done(8, 300);
        check("nack_empty", exp_q.size(), 0);

        // Exhaustion on requester 0, then pointer must favour requester 1
        ack_default = 1'b1;
        data_in[23:0] = 24'h340C00;
        push_exp(0, 24'h340C00, 1'b1, 4);
        req = 3'b001;
        wait_done(9, 300);
        ack_default = 1'b0;
        data_in[23:0] = 24'h341201;
        data_in[47:24] = 24'h340E42;
        push_exp(1, 24'h340E42, 1'b0, 1);
        push_exp(0, 24'h341201, 1'b0, 1);
        req = 3'b011;
        wait_done(11, 200);
        check("exh_empty", exp_q.size(), 0);

        // END never rises: every attempt times out
        model_mode = MNeverEnd;
        chk_len = 1'b1;
        data_in[47:24] = 24'h400A11;
        push_exp(1, 24'h400A11, 1'b1, 4);
        req = 3'b010;
        wait_done(12, 600);

        // Stale END: never drops, must not be taken as completion
        model_mode = MStale;
        data_in[71:48] = 24'h341E00;
        push_exp(2, 24'h341E00, 1'b1, 4);
        req = 3'b100;
        wait_done(13, 600);
        chk_len = 1'b0;
        model_mode = MNormal;
        check("tmo_empty", exp_q.size(), 0);

        // Async reset in WAIT_END, pointer back to 0 afterwards
        data_in[23:0] = 24'h341001;
        push_exp(0, 24'h341001, 1'b0, 1);
        req = 3'b001;
        wait_done(14, 200);
        hold_cyc = 40;
        data_in[23:0] = 24'h340A06;
        data_in[71:48] = 24'h340817;
        req = 3'b101;
        n = 0;
        while (!(oI2C_GO && !i2c_end) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_wait_end", 32'(oI2C_GO && !i2c_end), 1);
        check("pre_rst_gnt", 32'(oGNT), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_go", 32'(oI2C_GO), 0);
        check("arst_gnt", 32'(oGNT), 0);
        check("arst_busy", 32'(oBUSY), 0);
        push_exp(0, 24'h340A06, 1'b0, 1);
        push_exp(2, 24'h340817, 1'b0, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(16, 300);
        check("arst_empty", exp_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
